// File: rtl/link_block_sync_132.sv
// rtl/link_block_sync_132.sv - 132-bit block synchroniser with hunt/locked FSM
module link_block_sync_132 #(
  parameter int LOCK_CNT = 64,
  parameter int ERR_WIN  = 64,
  parameter int ERR_MAX  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [131:0] i_din,
  input  logic         i_din_valid,
  output logic [127:0] o_dout,
  output logic         o_dout_valid,
  output logic         o_dout_ctrl,
  output logic         o_dout_err,
  output logic         o_block_lock,
  output logic         o_slip,
  output logic [15:0]  o_hdr_err_total
);

  localparam int MAXP = (LOCK_CNT > ERR_WIN) ?
                        ((LOCK_CNT > ERR_MAX) ? LOCK_CNT : ERR_MAX) :
                        ((ERR_WIN  > ERR_MAX) ? ERR_WIN  : ERR_MAX);
  localparam int CW = $clog2(MAXP + 1);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(ERR_WIN - 1);
  localparam logic [CW-1:0] ERR_LAST  = CW'(ERR_MAX - 1);

  localparam logic [3:0] HDR_DATA = 4'b0101;
  localparam logic [3:0] HDR_CTRL = 4'b1010;

  typedef enum logic {S_HUNT = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_good_cnt;
  logic [CW-1:0]  r_blk_cnt;
  logic [CW-1:0]  r_err_cnt;

  logic [3:0]     w_hdr;
  logic           w_good;
  logic           w_bad;
  logic           w_ctrl;
  logic           w_hunt_blk;
  logic           w_lock_blk;
  logic           w_lock_done;
  logic           w_lose_lock;
  logic           w_win_end;

  assign w_hdr      = i_din[131:128];
  assign w_ctrl     = (w_hdr == HDR_CTRL);
  assign w_good     = (w_hdr == HDR_DATA) || w_ctrl;
  assign w_bad      = ~w_good;
  assign w_hunt_blk = i_din_valid && (r_state == S_HUNT);
  assign w_lock_blk = i_din_valid && (r_state == S_LOCKED);

  // Decision points: lock acquired, lock lost (beats window end), window end
  assign w_lock_done = w_hunt_blk && w_good && (r_good_cnt == LOCK_LAST);
  assign w_lose_lock = w_lock_blk && w_bad  && (r_err_cnt == ERR_LAST);
  assign w_win_end   = w_lock_blk && (r_blk_cnt == WIN_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HUNT;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_lock_done) w_state_nxt = S_LOCKED;
    if (w_lose_lock) w_state_nxt = S_HUNT;
  end

  // Lock indication follows the state register directly
  always_comb begin
    o_block_lock = (r_state == S_LOCKED);
  end

  // Good-header, window and error counters; frozen while no block is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_good_cnt <= '0;
      r_blk_cnt  <= '0;
      r_err_cnt  <= '0;
    end else if (w_hunt_blk) begin
      if (w_bad || w_lock_done) begin
        r_good_cnt <= '0;
        r_blk_cnt  <= '0;
        r_err_cnt  <= '0;
      end else begin
        r_good_cnt <= r_good_cnt + 1'b1;
      end
    end else if (w_lock_blk) begin
      if (w_lose_lock || w_win_end) begin
        r_good_cnt <= '0;
        r_blk_cnt  <= '0;
        r_err_cnt  <= '0;
      end else begin
        r_blk_cnt <= r_blk_cnt + 1'b1;
        r_err_cnt <= r_err_cnt + {{(CW-1){1'b0}}, w_bad};
      end
    end
  end

  // Forwarding path, slip pulse and lifetime bad-header count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_dout          <= '0;
      o_dout_valid    <= 1'b0;
      o_dout_ctrl     <= 1'b0;
      o_dout_err      <= 1'b0;
      o_slip          <= 1'b0;
      o_hdr_err_total <= '0;
    end else begin
      o_dout_valid <= w_lock_blk;
      o_slip       <= w_hunt_blk && w_bad;
      if (w_lock_blk) begin
        o_dout      <= i_din[127:0];
        o_dout_ctrl <= w_ctrl;
        o_dout_err  <= w_bad;
      end
      if (i_din_valid && w_bad && (o_hdr_err_total != 16'hFFFF))
        o_hdr_err_total <= o_hdr_err_total + 16'd1;
    end
  end

endmodule

// File: tb/tb_link_block_sync_132.sv
// tb/tb_link_block_sync_132.sv - scoreboard bench for link_block_sync_132
module tb_link_block_sync_132;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [131:0] din;
  logic         din_valid;
  logic [127:0] dout;
  logic         dout_valid;
  logic         dout_ctrl;
  logic         dout_err;
  logic         block_lock;
  logic         slip;
  logic [15:0]  hdr_err_total;

  typedef struct packed {
    logic [127:0] d;
    logic         c;
    logic         e;
  } exp_t;

  exp_t q[$];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   slip_cnt = 0;
  int   s0;

  always #5 clk = ~clk;

  link_block_sync_132 dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_din           (din),
    .i_din_valid     (din_valid),
    .o_dout          (dout),
    .o_dout_valid    (dout_valid),
    .o_dout_ctrl     (dout_ctrl),
    .o_dout_err      (dout_err),
    .o_block_lock    (block_lock),
    .o_slip          (slip),
    .o_hdr_err_total (hdr_err_total)
  );

  function automatic logic [127:0] pay(input int i);
    logic [31:0] v;
    v = i;
    return {32'hC0DE0000 + v, ~v, 32'h12345678 ^ v, v};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT forwards a block
  always @(negedge clk) begin
    exp_t e;
    if (slip === 1'b1) slip_cnt++;
    if (dout_valid === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got dout=%h ctrl=%b err=%b required no output",
                 dout, dout_ctrl, dout_err);
      end else begin
        e = q.pop_front();
        if (dout !== e.d || dout_ctrl !== e.c || dout_err !== e.e) begin
          n_fail++;
          $display("FAIL forwarded_block: got dout=%h ctrl=%b err=%b required dout=%h ctrl=%b err=%b",
                   dout, dout_ctrl, dout_err, e.d, e.c, e.e);
        end
      end
    end
  end

  task automatic send(input logic [3:0] h, input int idx, input bit fwd,
                      input bit ectrl, input bit eerr);
    exp_t e;
    @(negedge clk);
    din       = {h, pay(idx)};
    din_valid = 1'b1;
    if (fwd) begin
      e.d = pay(idx);
      e.c = ectrl;
      e.e = eerr;
      q.push_back(e);
    end
  endtask

  task automatic gap();
    @(negedge clk);
    din_valid = 1'b0;
    din       = {4'b0101, {128{1'b1}}};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    din_valid = 1'b0;
    din = '0;
    repeat (3) @(negedge clk);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_block_lock", block_lock, 0);
    check("reset_slip", slip, 0);
    check("reset_err_total", hdr_err_total, 0);
    check("reset_dout", dout, 0);
    rst_n = 1'b1;

    // 1: 64 good data blocks lock, block 65 forwarded as data
    for (int i = 0; i < 63; i++) send(4'b0101, i, 0, 0, 0);
    gap();
    check("t1_lock_after_63", block_lock, 0);
    send(4'b0101, 63, 0, 0, 0);
    gap();
    check("t1_lock_after_64", block_lock, 1);
    send(4'b0101, 64, 1, 0, 0);
    gap(); gap();
    check("t1_err_total", hdr_err_total, 0);

    // 2: bad header during hunt restarts the count
    do_reset();
    s0 = slip_cnt;
    for (int i = 0; i < 10; i++) send(4'b0101, 100 + i, 0, 0, 0);
    send(4'b0000, 110, 0, 0, 0);
    for (int i = 0; i < 63; i++) send(4'b0101, 111 + i, 0, 0, 0);
    gap(); gap();
    check("t2_slip_pulses", slip_cnt - s0, 1);
    check("t2_lock_after_63", block_lock, 0);
    send(4'b0101, 174, 0, 0, 0);
    gap();
    check("t2_lock_after_64", block_lock, 1);
    check("t2_err_total", hdr_err_total, 1);

    // 3: 15 bad per window for two windows keeps lock
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 64; i++) begin
        if (i < 15) send(4'b1111, 200 + 64 * w + i, 1, 0, 1);
        else        send(4'b0101, 200 + 64 * w + i, 1, 0, 0);
      end
      gap();
      check("t3_lock_held", block_lock, 1);
    end
    gap();
    check("t3_err_total", hdr_err_total, 31);
    check("t3_no_slip_locked", slip_cnt - s0, 1);

    // 4: 16th bad in a window drops lock after forwarding it
    for (int i = 0; i < 16; i++) send(4'b0011, 400 + i, 1, 0, 1);
    for (int i = 0; i < 3; i++) send(4'b0101, 416 + i, 0, 0, 0);
    gap();
    check("t4_lock_lost", block_lock, 0);
    check("t4_err_total", hdr_err_total, 47);

    // 5: gaps between every block; alternating control/data once locked
    do_reset();
    for (int i = 0; i < 64; i++) begin
      send(4'b0101, 500 + i, 0, 0, 0);
      gap();
      if (i == 62) check("t5_lock_after_63_gapped", block_lock, 0);
    end
    check("t5_lock_after_64_gapped", block_lock, 1);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send(4'b1010, 600 + i, 1, 1, 0);
      else            send(4'b0101, 600 + i, 1, 0, 0);
      gap(); gap();
    end
    send(4'b0000, 608, 1, 0, 1);
    gap(); gap();
    check("t5_err_total", hdr_err_total, 1);
    check("t5_lock_held", block_lock, 1);

    // 6: asynchronous reset while locked and forwarding
    send(4'b1010, 700, 0, 0, 0);
    @(posedge clk);
    #1;
    check("t6_pre_dout_valid", dout_valid, 1);
    #1;
    rst_n = 1'b0;
    din_valid = 1'b0;
    #1;
    check("t6_async_dout_valid", dout_valid, 0);
    check("t6_async_dout", dout, 0);
    check("t6_async_ctrl", dout_ctrl, 0);
    check("t6_async_lock", block_lock, 0);
    check("t6_async_err_total", hdr_err_total, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 63; i++) send(4'b0101, 800 + i, 0, 0, 0);
    gap();
    check("t6_relock_after_63", block_lock, 0);
    send(4'b0101, 863, 0, 0, 0);
    gap();
    check("t6_relock_after_64", block_lock, 1);

    gap(); gap();
    check("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
